// File: rtl/mem_1rw1rw_port_arb_if.sv
// Bundle of requester-side handshake signals and the RAM port A/B command/data buses.
interface mem_1rw1rw_port_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_ADDR = 8,
  parameter int WIDTH_DATA = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ*WIDTH_ADDR-1:0] req_addr;
  logic [NUM_REQ*WIDTH_DATA-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ*WIDTH_DATA-1:0] rsp_data;
  logic [WIDTH_ADDR-1:0]         mem_addra;
  logic [WIDTH_DATA-1:0]         mem_dina;
  logic                          mem_wena;
  logic                          mem_rena;
  logic [WIDTH_DATA-1:0]         mem_douta;
  logic [WIDTH_ADDR-1:0]         mem_addrb;
  logic [WIDTH_DATA-1:0]         mem_dinb;
  logic                          mem_wenb;
  logic                          mem_renb;
  logic [WIDTH_DATA-1:0]         mem_doutb;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, mem_douta, mem_doutb,
    output req_ready, rsp_valid, rsp_data,
    output mem_addra, mem_dina, mem_wena, mem_rena,
    output mem_addrb, mem_dinb, mem_wenb, mem_renb
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, mem_douta, mem_doutb,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_addra, mem_dina, mem_wena, mem_rena,
    input  mem_addrb, mem_dinb, mem_wenb, mem_renb
  );
endinterface

// File: rtl/mem_1rw1rw_port_arb.sv
// Round-robin arbiter sharing both ports of a 1rw1rw RAM among NUM_REQ requesters,
// with registered RAM commands and per-port tag pipelines routing read data back.
module mem_1rw1rw_port_arb #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_ADDR = 8,
  parameter int WIDTH_DATA = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_1rw1rw_port_arb_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW  = WIDTH_ADDR;
  localparam int DW  = WIDTH_DATA;

  logic [IDW-1:0] r_rrPtr;
  logic           w_foundA, w_foundB, w_grantB, w_conflict;
  logic [IDW-1:0] w_idxA, w_idxB, w_lastIdx, w_nextPtr;
  logic [IDW:0]   w_scan;
  logic [AW-1:0]  w_addrA, w_addrB;
  logic [DW-1:0]  w_wdataA, w_wdataB;
  logic           w_wrA, w_wrB;

  logic [AW-1:0]  r_addrA, r_addrB;
  logic [DW-1:0]  r_dinA, r_dinB;
  logic           r_wenA, r_renA, r_wenB, r_renB;
  logic [IDW-1:0] r_idA, r_idB;

  logic [RD_LATENCY-1:0]          r_tagValidA, r_tagValidB;
  logic [RD_LATENCY-1:0][IDW-1:0] r_tagIdA, r_tagIdB;

  // Scan from r_rrPtr upward (wrapping) and pick the first two valid requesters.
  always_comb begin
    w_foundA = 1'b0;
    w_foundB = 1'b0;
    w_idxA   = '0;
    w_idxB   = '0;
    w_scan   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = {1'b0, r_rrPtr} + (IDW+1)'(k);
      if (w_scan >= (IDW+1)'(NUM_REQ)) w_scan = w_scan - (IDW+1)'(NUM_REQ);
      if (bus.req_valid[w_scan[IDW-1:0]]) begin
        if (!w_foundA) begin
          w_foundA = 1'b1;
          w_idxA   = w_scan[IDW-1:0];
        end else if (!w_foundB) begin
          w_foundB = 1'b1;
          w_idxB   = w_scan[IDW-1:0];
        end
      end
    end
  end

  assign w_addrA  = bus.req_addr[int'(w_idxA)*AW +: AW];
  assign w_addrB  = bus.req_addr[int'(w_idxB)*AW +: AW];
  assign w_wdataA = bus.req_wdata[int'(w_idxA)*DW +: DW];
  assign w_wdataB = bus.req_wdata[int'(w_idxB)*DW +: DW];
  assign w_wrA    = bus.req_wr[w_idxA];
  assign w_wrB    = bus.req_wr[w_idxB];

  // Same address with a write involved: port B is held off so the two accesses serialise.
  assign w_conflict = w_foundB && (w_addrA == w_addrB) && (w_wrA || w_wrB);
  assign w_grantB   = w_foundB && !w_conflict;
  assign w_lastIdx  = w_grantB ? w_idxB : w_idxA;
  assign w_nextPtr  = (w_lastIdx == IDW'(NUM_REQ-1)) ? '0 : w_lastIdx + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (w_foundA) bus.req_ready[w_idxA] = 1'b1;
    if (w_grantB) bus.req_ready[w_idxB] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rrPtr <= '0;
    end else if (w_foundA) begin
      r_rrPtr <= w_nextPtr;
    end
  end

  // Command registers: enables pulse per grant, address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addrA <= '0;
      r_dinA  <= '0;
      r_wenA  <= 1'b0;
      r_renA  <= 1'b0;
      r_idA   <= '0;
      r_addrB <= '0;
      r_dinB  <= '0;
      r_wenB  <= 1'b0;
      r_renB  <= 1'b0;
      r_idB   <= '0;
    end else begin
      r_wenA <= w_foundA && w_wrA;
      r_renA <= w_foundA && !w_wrA;
      r_wenB <= w_grantB && w_wrB;
      r_renB <= w_grantB && !w_wrB;
      if (w_foundA) begin
        r_addrA <= w_addrA;
        r_dinA  <= w_wdataA;
        r_idA   <= w_idxA;
      end
      if (w_grantB) begin
        r_addrB <= w_addrB;
        r_dinB  <= w_wdataB;
        r_idB   <= w_idxB;
      end
    end
  end

  assign bus.mem_addra = r_addrA;
  assign bus.mem_dina  = r_dinA;
  assign bus.mem_wena  = r_wenA;
  assign bus.mem_rena  = r_renA;
  assign bus.mem_addrb = r_addrB;
  assign bus.mem_dinb  = r_dinB;
  assign bus.mem_wenb  = r_wenB;
  assign bus.mem_renb  = r_renB;

  // Tags track each read through the RAM so the data lands on the issuing requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tagValidA <= '0;
      r_tagValidB <= '0;
      r_tagIdA    <= '0;
      r_tagIdB    <= '0;
    end else begin
      r_tagValidA[0] <= r_renA;
      r_tagIdA[0]    <= r_idA;
      r_tagValidB[0] <= r_renB;
      r_tagIdB[0]    <= r_idB;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tagValidA[i] <= r_tagValidA[i-1];
        r_tagIdA[i]    <= r_tagIdA[i-1];
        r_tagValidB[i] <= r_tagValidB[i-1];
        r_tagIdB[i]    <= r_tagIdB[i-1];
      end
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    if (r_tagValidA[RD_LATENCY-1]) begin
      bus.rsp_valid[r_tagIdA[RD_LATENCY-1]] = 1'b1;
      bus.rsp_data[int'(r_tagIdA[RD_LATENCY-1])*DW +: DW] = bus.mem_douta;
    end
    if (r_tagValidB[RD_LATENCY-1]) begin
      bus.rsp_valid[r_tagIdB[RD_LATENCY-1]] = 1'b1;
      bus.rsp_data[int'(r_tagIdB[RD_LATENCY-1])*DW +: DW] = bus.mem_doutb;
    end
  end
endmodule
